// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, zero pad, FCS and inter-frame gap; aborts on underflow/oversize.
// Outputs lag the accepting state by one cycle; define MAC_TX_FRAMER_STATS_EN for frame counters.
module mac_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int IFG_LEN      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort
`ifdef MAC_TX_FRAMER_STATS_EN
    ,
    output logic [31:0] stat_ok,
    output logic [15:0] stat_abort
`endif
);
    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_FRAME);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_FRAME);
    localparam logic [5:0]    PRE_LAST = 6'(PREAMBLE_LEN > 1 ? PREAMBLE_LEN - 2 : 0);
    localparam logic [5:0]    IFG_LAST = 6'(IFG_LEN);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]    tmr_q, tmr_d;
    logic [31:0]   crc_q, crc_d, crc_inv;
    logic [7:0]    txd_q, txd_d;
    logic          tx_en_q, tx_en_d, tx_er_q, tx_er_d, done_q, done_d, abort_q, abort_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign crc_inv = ~crc_q;

    // State names the byte being registered for the next cycle, so DATA already accepts while SFD is on the wire.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        crc_d   = crc_q;
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                crc_d = 32'hFFFF_FFFF;
                tmr_d = '0;
                if (s_valid) begin
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                    state_d = (PREAMBLE_LEN > 1) ? PRE : SFD;
                end
            end
            PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                tmr_d   = tmr_q + 6'd1;
                if (tmr_q == PRE_LAST) begin
                    tmr_d   = '0;
                    state_d = SFD;
                end
            end
            SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                if (!s_valid || (!s_last && cnt_inc >= MAX_C)) begin
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    txd_d   = s_data;
                    tx_en_d = 1'b1;
                    cnt_d   = cnt_inc;
                    crc_d   = crc_byte(crc_q, s_data);
                    if (s_last) begin
                        tmr_d   = '0;
                        state_d = (cnt_inc < MIN_C) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_inc;
                crc_d   = crc_byte(crc_q, 8'h00);
                if (cnt_inc >= MIN_C) begin
                    tmr_d   = '0;
                    state_d = FCS;
                end
            end
            FCS: begin
                txd_d   = crc_inv[{tmr_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                tmr_d   = tmr_q + 6'd1;
                if (tmr_q[1:0] == 2'd3) begin
                    done_d  = 1'b1;
                    tmr_d   = '0;
                    state_d = IFG;
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    tmr_d   = '0;
                    state_d = IFG;
                end
            end
            IFG: begin
                // First IFG cycle coincides with the last FCS byte on the wire, hence IFG_LEN+1 counts.
                tmr_d = tmr_q + 6'd1;
                if (tmr_q == IFG_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign s_ready     = (state_q == DATA) || (state_q == DRAIN);
    assign busy        = (state_q != IDLE);
    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = tx_en_q;
    assign gmii_tx_er  = tx_er_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

`ifdef MAC_TX_FRAMER_STATS_EN
    logic [31:0] stat_ok_q, stat_ok_d;
    logic [15:0] stat_abort_q, stat_abort_d;

    always_comb begin
        stat_ok_d    = stat_ok_q;
        stat_abort_d = stat_abort_q;
        if (done_d && stat_ok_q != '1)     stat_ok_d    = stat_ok_q + 32'd1;
        if (abort_d && stat_abort_q != '1) stat_abort_d = stat_abort_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok_q    <= '0;
            stat_abort_q <= '0;
        end else begin
            stat_ok_q    <= stat_ok_d;
            stat_abort_q <= stat_abort_d;
        end
    end

    assign stat_ok    = stat_ok_q;
    assign stat_abort = stat_abort_q;
`endif
endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: frames expand into expected wire bytes, a monitor pops and compares.
`timescale 1ns/1ps
module tb_mac_tx_framer;
    localparam int PRE_N = 7;
    localparam int MIN_F = 60;
    localparam int MAX_F = 1514;
    localparam int IFG_N = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, busy, frame_done, frame_abort;
`ifdef MAC_TX_FRAMER_STATS_EN
    logic [31:0] stat_ok;
    logic [15:0] stat_abort;
`endif

    mac_tx_framer #(
        .PREAMBLE_LEN(PRE_N), .MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F), .IFG_LEN(IFG_N)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
`ifdef MAC_TX_FRAMER_STATS_EN
        , .stat_ok(stat_ok), .stat_abort(stat_abort)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] txd;
        logic       er;
        logic       done;
        logic       abort;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ok = 0;
    int   exp_abort = 0;
    int   last_gap = 0;
    int   idle_run = 0;
    bit   in_frame = 1'b0;
    bit   was_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // FCS as serial division of the LSB-first bit stream by 0x04C11DB7.
    function automatic logic [31:0] fcs_reg(input logic [7:0] q[$]);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[31] ^ q[k][b];
                r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
            end
        end
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] pl[$], input int gap_at);
        logic [7:0]  w[$];
        logic [31:0] r;
        logic [7:0]  v;
        logic        lastb;
        int          n;
        for (int k = 0; k < PRE_N; k++) exp_q.push_back({8'h55, 4'b0000});
        exp_q.push_back({8'hD5, 4'b0000});
        if (gap_at >= 0 || pl.size() > MAX_F) begin
            n = (gap_at >= 0) ? gap_at : MAX_F - 1;
            for (int k = 0; k < n; k++) exp_q.push_back({pl[k], 4'b0000});
            exp_q.push_back({8'h00, 4'b1011});
            exp_abort++;
        end else begin
            w = pl;
            while (w.size() < MIN_F) w.push_back(8'h00);
            foreach (w[k]) exp_q.push_back({w[k], 4'b0000});
            r = fcs_reg(w);
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < 8; b++) v[b] = ~r[31 - 8 * j - b];
                lastb = (j == 3);
                exp_q.push_back({v, 1'b0, lastb, 1'b0, lastb});
            end
            exp_ok++;
        end
    endtask

    task automatic send_frame(input int len, input int gap_at, input int rst_at, input bit tog, input bit incr);
        logic [7:0] pl[$];
        int i, budget;
        for (int k = 0; k < len; k++) pl.push_back(incr ? 8'(k) : 8'($urandom_range(0, 255)));
        push_frame(pl, (rst_at >= 0) ? -1 : gap_at);
        i = 0;
        budget = 0;
        s_data = pl[0];
        s_last = (len == 1);
        s_valid = 1'b1;
        while (i < len) begin
            @(negedge clk);
            budget++;
            if (budget > len + 400) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", i, len);
                break;
            end
            if (s_ready) begin
                @(posedge clk);
                #1;
                i++;
                if (i == rst_at) begin
                    #2;
                    rst = 1'b1;
                    exp_q.delete();
                    exp_ok = 0;
                    exp_abort = 0;
                    #1;
                    check("rst_tx_en", 64'(gmii_tx_en), 64'(0));
                    check("rst_s_ready", 64'(s_ready), 64'(0));
                    check("rst_busy", 64'(busy), 64'(0));
                    s_valid = 1'b0;
                    s_last = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    break;
                end
                if (i < len) begin
                    if (i == gap_at) begin
                        s_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    s_data = pl[i];
                    s_last = (i == len - 1);
                    s_valid = 1'b1;
                end
            end else begin
                if (tog && busy && $urandom_range(0, 1) == 1) s_valid = 1'b0;
                @(posedge clk);
                #1;
                s_valid = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy || exp_q.size() != 0) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 4000) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b, %0d expected bytes outstanding", busy, exp_q.size());
        end
        check("idle_s_ready", 64'(s_ready), 64'(0));
    endtask

    // Monitor: every cycle with gmii_tx_en must match the next expected wire byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                was_en = 1'b0;
                idle_run = 0;
            end else begin
                if (gmii_tx_en) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%0h with nothing expected", gmii_txd);
                    end else begin
                        e = exp_q.pop_front();
                        check("wire_byte", 64'({gmii_txd, gmii_tx_er, frame_done, frame_abort}),
                              64'({e.txd, e.er, e.done, e.abort}));
                        in_frame = !e.last;
                    end
                    if (!was_en) last_gap = idle_run;
                    idle_run = 0;
                end else begin
                    check("idle_outputs", 64'({gmii_txd, gmii_tx_er, frame_done, frame_abort}), 64'(0));
                    if (in_frame) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_truncated: gmii_tx_en low, required high");
                        while (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            if (e.last) break;
                        end
                        in_frame = 1'b0;
                    end
                    idle_run++;
                end
                was_en = gmii_tx_en;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int len, gap;
        #1;
        rst = 1'b1;
        #2;
        check("reset_txd", 64'(gmii_txd), 64'(0));
        check("reset_tx_en", 64'(gmii_tx_en), 64'(0));
        check("reset_tx_er", 64'(gmii_tx_er), 64'(0));
        check("reset_s_ready", 64'(s_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_pulses", 64'({frame_done, frame_abort}), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        send_frame(60, -1, -1, 1'b0, 1'b1);
        wait_idle();
        send_frame(10, -1, -1, 1'b0, 1'b0);
        wait_idle();
        send_frame(40, 20, -1, 1'b0, 1'b0);
        send_frame(60, -1, -1, 1'b0, 1'b0);
        wait_idle();
        send_frame(64, -1, -1, 1'b0, 1'b0);
        send_frame(64, -1, -1, 1'b0, 1'b0);
        wait_idle();
        check("b2b_gap", 64'(last_gap), 64'(IFG_N + 1));

        send_frame(59, -1, -1, 1'b1, 1'b0);
        send_frame(60, -1, -1, 1'b1, 1'b0);
        send_frame(61, -1, -1, 1'b1, 1'b0);
        send_frame(1, -1, -1, 1'b1, 1'b0);
        wait_idle();
        send_frame(MAX_F, -1, -1, 1'b0, 1'b0);
        send_frame(MAX_F + 6, -1, -1, 1'b0, 1'b0);
        wait_idle();

        repeat (12) begin
            len = $urandom_range(1, 150);
            gap = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            send_frame(len, gap, -1, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        send_frame(60, -1, 30, 1'b0, 1'b0);
        send_frame(60, -1, -1, 1'b0, 1'b1);
        wait_idle();
`ifdef MAC_TX_FRAMER_STATS_EN
        check("stat_ok", 64'(stat_ok), 64'(exp_ok));
        check("stat_abort", 64'(stat_abort), 64'(exp_abort));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
